// File: rtl/alu_pkg.sv
// Shared types, frame geometry and CRC helpers for the serial ALU link.
// The CRC functions are used by the core and by the scoreboard alike.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b100,
    OP_SUB = 3'b101
  } op_e;

  typedef enum logic [2:0] {
    ERR_NONE = 3'b000,
    ERR_OP   = 3'b001,
    ERR_CRC  = 3'b010,
    ERR_DATA = 3'b100
  } err_e;

  localparam int unsigned PKT_LEN      = 11;
  localparam int unsigned RX_FRAME_LEN = 99;
  localparam int unsigned TX_FRAME_LEN = 55;
  localparam int unsigned RX_DATA_PKTS = RX_FRAME_LEN / PKT_LEN - 1;

  localparam logic [3:0] CRC4_POLY = 4'b0011;
  localparam logic [2:0] CRC3_POLY = 3'b011;

  function automatic logic [3:0] crc4_f(input logic [67:0] d);
    logic [3:0] c;
    logic       fb;
    c = '0;
    for (int unsigned i = 0; i < 68; i++) begin
      fb = c[3] ^ d[67 - i];
      c  = {c[2:0], 1'b0} ^ (fb ? CRC4_POLY : 4'b0000);
    end
    return c;
  endfunction

  function automatic logic [2:0] crc3_f(input logic [36:0] d);
    logic [2:0] c;
    logic       fb;
    c = '0;
    for (int unsigned i = 0; i < 37; i++) begin
      fb = c[2] ^ d[36 - i];
      c  = {c[1:0], 1'b0} ^ (fb ? CRC3_POLY : 3'b000);
    end
    return c;
  endfunction

  function automatic logic op_valid(input logic [2:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB: return 1'b1;
      default:                       return 1'b0;
    endcase
  endfunction

  function automatic logic [10:0] pkt_f(input logic typ, input logic [7:0] pay);
    return {1'b0, typ, pay, 1'b1};
  endfunction

endpackage

// File: rtl/alu_serial_core_if.sv
// Serial link between the ALU BFM (master) and the responder core (slave).
interface alu_serial_core_if;
  logic sin;
  logic sout;

  modport slave  (input sin, output sout);
  modport master (output sin, input sout);
endinterface

// File: rtl/alu_serial_tx.sv
// Response serialiser: shifts out a left-aligned frame of len bits, idles high.
module alu_serial_tx import alu_pkg::*; (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [TX_FRAME_LEN-1:0] frame,
  input  logic [5:0]              len,
  input  logic                    start,
  output logic                    busy,
  output logic                    sout
);

  logic [TX_FRAME_LEN-1:0] sh;
  logic [5:0]              cnt;

  // First bit leaves on the start edge; cnt tracks the bits still to send.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh   <= '0;
      cnt  <= '0;
      sout <= 1'b1;
    end else if (start) begin
      sout <= frame[TX_FRAME_LEN-1];
      sh   <= {frame[TX_FRAME_LEN-2:0], 1'b1};
      cnt  <= len - 6'd1;
    end else if (cnt != '0) begin
      sout <= sh[TX_FRAME_LEN-1];
      sh   <= {sh[TX_FRAME_LEN-2:0], 1'b1};
      cnt  <= cnt - 6'd1;
    end else begin
      sout <= 1'b1;
    end
  end

  assign busy = start || (cnt != '0);

endmodule

// File: rtl/alu_serial_core.sv
// Serial ALU responder: receives B/A/command packets, checks them, executes
// and returns a result frame or a single error packet.
module alu_serial_core import alu_pkg::*; #(
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input logic               clk,
  input logic               rst_n,
  alu_serial_core_if.slave  bus
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_RX_BITS, S_CHECK, S_EXEC} state_e;

  state_e                  state, state_nxt;
  logic [3:0]              bcnt;
  logic [9:0]              rx_sh;
  logic [63:0]             ab;
  logic [3:0]              dcnt;
  logic                    data_err;
  logic [2:0]              op_q;
  logic [3:0]              crc_q;
  logic [TW-1:0]           idle_cnt;
  logic                    sample, check, tx_start, idle_wait, timeout;
  logic                    tx_busy;
  logic [TX_FRAME_LEN-1:0] tx_frame;
  logic [5:0]              tx_len;
  logic [31:0]             a, b, res;
  logic [32:0]             sum, dif;
  logic                    cy, ov;
  logic [3:0]              flags;
  err_e                    err;
  logic [7:0]              epay;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // CHECK also accepts a start bit so back-to-back packets are not missed.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (!tx_busy && !bus.sin) state_nxt = S_RX_BITS;
      S_RX_BITS: if (bcnt == 4'd9)         state_nxt = S_CHECK;
      S_CHECK: begin
        if (rx_sh[9])      state_nxt = S_EXEC;
        else if (!bus.sin) state_nxt = S_RX_BITS;
        else               state_nxt = S_IDLE;
      end
      S_EXEC:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    sample    = (state == S_RX_BITS);
    check     = (state == S_CHECK);
    tx_start  = (state == S_EXEC);
    idle_wait = (state == S_IDLE) && (dcnt != '0);
    timeout   = idle_wait && (idle_cnt == TW'(TIMEOUT_CYC - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt     <= '0;
      rx_sh    <= '0;
      ab       <= '0;
      dcnt     <= '0;
      data_err <= 1'b0;
      op_q     <= '0;
      crc_q    <= '0;
      idle_cnt <= '0;
    end else begin
      bcnt <= sample ? bcnt + 4'd1 : '0;
      if (sample) rx_sh <= {rx_sh[8:0], bus.sin};
      if (check) begin
        if (!rx_sh[0]) data_err <= 1'b1;
        if (rx_sh[9]) begin
          op_q  <= rx_sh[7:5];
          crc_q <= rx_sh[4:1];
        end else if (dcnt == 4'(RX_DATA_PKTS)) begin
          data_err <= 1'b1;
        end else begin
          dcnt <= dcnt + 4'd1;
          ab   <= {ab[55:0], rx_sh[8:1]};
        end
      end
      if (tx_start || timeout) begin
        dcnt     <= '0;
        data_err <= 1'b0;
      end
      idle_cnt <= (idle_wait && !timeout) ? idle_cnt + 1'b1 : '0;
    end
  end

  // Result is captured by the serialiser on the EXEC edge.
  always_comb begin
    b   = ab[63:32];
    a   = ab[31:0];
    sum = {1'b0, a} + {1'b0, b};
    dif = {1'b0, a} - {1'b0, b};
    res = '0;
    cy  = 1'b0;
    ov  = 1'b0;
    case (op_q)
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_ADD: begin
        res = sum[31:0];
        cy  = sum[32];
        ov  = (a[31] == b[31]) && (res[31] != a[31]);
      end
      OP_SUB: begin
        res = dif[31:0];
        cy  = dif[32];
        ov  = (a[31] != b[31]) && (res[31] != a[31]);
      end
      default: ;
    endcase
    flags = {cy, ov, res == '0, res[31]};

    if (data_err || dcnt != 4'(RX_DATA_PKTS))     err = ERR_DATA;
    else if (crc4_f({ab, 1'b1, op_q}) != crc_q)    err = ERR_CRC;
    else if (!op_valid(op_q))                      err = ERR_OP;
    else                                           err = ERR_NONE;

    epay    = {1'b1, err, err, 1'b0};
    epay[0] = ^epay[7:1];

    if (err != ERR_NONE) begin
      tx_frame = {pkt_f(1'b1, epay), 44'b0};
      tx_len   = 6'(PKT_LEN);
    end else begin
      tx_frame = {pkt_f(1'b0, res[31:24]), pkt_f(1'b0, res[23:16]),
                  pkt_f(1'b0, res[15:8]),  pkt_f(1'b0, res[7:0]),
                  pkt_f(1'b1, {1'b0, flags, crc3_f({res, 1'b0, flags})})};
      tx_len   = 6'(TX_FRAME_LEN);
    end
  end

  alu_serial_tx u_tx (
    .clk   (clk),
    .rst_n (rst_n),
    .frame (tx_frame),
    .len   (tx_len),
    .start (tx_start),
    .busy  (tx_busy),
    .sout  (bus.sout)
  );

endmodule

// File: tb/tb_alu_serial_core.sv
// Directed bench for alu_serial_core: drives sin as the BFM and checks sout frames.
module tb_alu_serial_core;
  import alu_pkg::*;

  localparam int unsigned TIMEOUT = 1000;

  logic        clk;
  logic        rst_n;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  alu_serial_core_if bus();

  alu_serial_core #(.TIMEOUT_CYC(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input logic typ, input logic [7:0] pay, input logic stop);
    logic [10:0] p;
    p = {1'b0, typ, pay, stop};
    for (int i = 10; i >= 0; i--) begin
      bus.sin = p[i];
      tick();
    end
  endtask

  task automatic send_frame(input logic [31:0] b, input logic [31:0] a, input logic [2:0] op,
                            input logic [3:0] crc, input int ndata, input int gap,
                            input int bad_stop);
    logic [63:0] ba;
    logic [7:0]  byt;
    ba = {b, a};
    for (int i = 0; i < ndata; i++) begin
      if (i < 8) byt = ba[63 - 8*i -: 8];
      else       byt = 8'h00;
      send_pkt(1'b0, byt, i != bad_stop);
      for (int g = 0; g < gap; g++) begin
        bus.sin = 1'b1;
        tick();
      end
    end
    send_pkt(1'b1, {1'b0, op, crc}, 1'b1);
  endtask

  // Called right after the CMD stop bit edge: one quiet cycle, then the frame.
  task automatic get_resp(input string tag, input int unsigned nbits, output logic [54:0] got);
    tick();
    chk({tag, "_lat"}, bus.sout, 1'b1);
    got = '0;
    for (int unsigned i = 0; i < nbits; i++) begin
      tick();
      got = {got[53:0], bus.sout};
    end
  endtask

  function automatic logic [54:0] ok_frame(input logic [31:0] c, input logic [3:0] f);
    logic [2:0] k;
    k = crc3_f({c, 1'b0, f});
    return {2'b00, c[31:24], 1'b1, 2'b00, c[23:16], 1'b1,
            2'b00, c[15:8],  1'b1, 2'b00, c[7:0],   1'b1,
            2'b01, 1'b0, f, k, 1'b1};
  endfunction

  task automatic run_ok(input string tag, input logic [31:0] b, input logic [31:0] a,
                        input logic [2:0] op, input logic [31:0] c, input logic [3:0] f,
                        input int gap);
    logic [54:0] got;
    send_frame(b, a, op, crc4_f({b, a, 1'b1, op}), 8, gap, -1);
    get_resp(tag, 55, got);
    chk(tag, got, ok_frame(c, f));
    tick();
    chk({tag, "_idle"}, bus.sout, 1'b1);
  endtask

  task automatic run_err(input string tag, input logic [31:0] b, input logic [31:0] a,
                         input logic [2:0] op, input logic [3:0] crc, input int ndata,
                         input int bad_stop, input logic [7:0] pay);
    logic [54:0] got;
    send_frame(b, a, op, crc, ndata, 0, bad_stop);
    get_resp(tag, 11, got);
    chk(tag, got[10:0], {2'b01, pay, 1'b1});
    tick();
    chk({tag, "_idle"}, bus.sout, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned zeros;
    logic [3:0]  crc_ok;

    bus.sin = 1'b1;
    rst_n   = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_sout", bus.sout, 1'b1);
    rst_n = 1'b1;
    tick();

    run_ok("add_small",  32'h0000_0002, 32'h0000_0001, OP_ADD, 32'h0000_0003, 4'b0000, 0);
    run_ok("add_gaps",   32'h0000_0002, 32'h0000_0001, OP_ADD, 32'h0000_0003, 4'b0000, 3);
    run_ok("add_wrap",   32'h0000_0001, 32'hFFFF_FFFF, OP_ADD, 32'h0000_0000, 4'b1010, 0);
    run_ok("sub_ovf",    32'h0000_0001, 32'h8000_0000, OP_SUB, 32'h7FFF_FFFF, 4'b0100, 0);
    run_ok("sub_borrow", 32'h0000_0005, 32'h0000_0003, OP_SUB, 32'hFFFF_FFFE, 4'b1001, 0);

    run_err("op_bad", 32'h0000_0003, 32'h0000_0005, 3'b111,
            crc4_f({32'h0000_0003, 32'h0000_0005, 1'b1, 3'b111}), 8, -1, 8'b1001_0011);
    crc_ok = crc4_f({32'h0000_0002, 32'h0000_0001, 1'b1, 3'b100});
    run_err("crc_bad",  32'h0000_0002, 32'h0000_0001, OP_ADD, crc_ok ^ 4'b0001, 8, -1, 8'b1010_0101);
    run_err("data_7",   32'h0000_0002, 32'h0000_0001, OP_ADD, crc_ok, 7, -1, 8'b1100_1001);
    run_err("data_9",   32'h0000_0002, 32'h0000_0001, OP_ADD, crc_ok, 9, -1, 8'b1100_1001);
    run_err("bad_stop", 32'h0000_0002, 32'h0000_0001, OP_ADD, crc_ok, 8, 2, 8'b1100_1001);
    run_err("prio_data", 32'h0000_0002, 32'h0000_0001, 3'b111, crc_ok ^ 4'b0001, 7, -1, 8'b1100_1001);
    run_err("prio_crc",  32'h0000_0002, 32'h0000_0001, 3'b110, crc_ok ^ 4'b0001, 8, -1, 8'b1010_0101);

    for (int i = 0; i < 8; i++) send_pkt(1'b0, 8'(8'hA0 + i), 1'b1);
    bus.sin = 1'b1;
    zeros = 0;
    repeat (TIMEOUT + 20) begin
      tick();
      if (bus.sout !== 1'b1) zeros++;
    end
    chk("timeout_quiet", zeros, 0);
    run_ok("after_timeout", 32'h0F0F_0000, 32'h1234_5678, OP_OR, 32'h1F3F_5678, 4'b0000, 0);

    send_frame(32'h0000_0002, 32'h0000_0001, OP_ADD, crc_ok, 8, 0, -1);
    tick();
    repeat (20) tick();
    chk("pre_rst_bit", bus.sout, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk("rst_async", bus.sout, 1'b1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    zeros = 0;
    repeat (30) begin
      tick();
      if (bus.sout !== 1'b1) zeros++;
    end
    chk("rst_quiet", zeros, 0);
    run_ok("and_after_rst", 32'hFF00_FF00, 32'hF0F0_F0F0, OP_AND, 32'hF000_F000, 4'b0001, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
